ace_mem_responder: RTL

ACE_MEM_RESPONDER -- requirements
Module: ace_mem_responder

---
 rtl/ace_mem_responder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ace_mem_responder.sv
// Single-port-per-channel ACE-style memory responder: independent read and write
// FSMs over a word memory with a per-word presence (sharer) bit and transaction counters.
module ace_mem_responder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic        WVALID,
  output logic        WREADY,
  output logic        BVALID,
  input  logic        BREADY,
  output logic        Shared_line,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 1 << IW;

  typedef enum logic {R_IDLE, R_DATA}    r_state_t;
  typedef enum logic {W_COLLECT, W_RESP} w_state_t;

  r_state_t r_state;
  w_state_t w_state;

  logic [31:0]      mem [WORDS];
  logic [WORDS-1:0] presence;

  logic [IW-1:0] ar_idx, aw_in_idx, r_idx, aw_idx, commit_idx;
  logic [31:0]   rdata_q, wdata_q, commit_data;
  logic          shared_q, aw_done, w_done;
  logic [15:0]   rd_cnt, wr_cnt;
  logic          ar_fire, r_fire, aw_fire, w_fire, commit;
  logic          unused_addr_bits;

  // Address bits outside the decoded word index alias silently.
  assign unused_addr_bits = ^{ARADDR[31:ADDR_WIDTH], ARADDR[1:0],
                              AWADDR[31:ADDR_WIDTH], AWADDR[1:0]};

  assign ar_idx    = ARADDR[ADDR_WIDTH-1:2];
  assign aw_in_idx = AWADDR[ADDR_WIDTH-1:2];

  assign ARREADY     = (r_state == R_IDLE);
  assign RVALID      = (r_state == R_DATA);
  assign RDATA       = rdata_q;
  assign Shared_line = shared_q;
  assign AWREADY     = (w_state == W_COLLECT) && !aw_done;
  assign WREADY      = (w_state == W_COLLECT) && !w_done;
  assign BVALID      = (w_state == W_RESP);
  assign rd_count    = rd_cnt;
  assign wr_count    = wr_cnt;

  always_comb begin
    ar_fire     = ARVALID && (r_state == R_IDLE);
    r_fire      = RREADY && (r_state == R_DATA);
    aw_fire     = AWVALID && AWREADY;
    w_fire      = WVALID && WREADY;
    commit      = (w_state == W_COLLECT) && (aw_done || aw_fire) && (w_done || w_fire);
    commit_idx  = aw_done ? aw_idx : aw_in_idx;
    commit_data = w_done ? wdata_q : WDATA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      rdata_q  <= '0;
      shared_q <= 1'b0;
      r_idx    <= '0;
      rd_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (ar_fire) begin
          rdata_q  <= mem[ar_idx];
          shared_q <= presence[ar_idx];
          r_idx    <= ar_idx;
          r_state  <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          shared_q <= 1'b0;
          rd_cnt   <= rd_cnt + 16'd1;
          r_state  <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // The clear is scheduled after the set so a commit to the same word wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      presence <= '0;
    end else begin
      if (r_fire) presence[r_idx] <= 1'b1;
      if (commit) presence[commit_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_COLLECT;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wr_cnt  <= '0;
    end else begin
      case (w_state)
        W_COLLECT: begin
          if (aw_fire) begin
            aw_done <= 1'b1;
            aw_idx  <= aw_in_idx;
          end
          if (w_fire) begin
            w_done  <= 1'b1;
            wdata_q <= WDATA;
          end
          if (commit) w_state <= W_RESP;
        end
        W_RESP: if (BREADY) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          wr_cnt  <= wr_cnt + 16'd1;
          w_state <= W_COLLECT;
        end
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // Memory contents survive reset; only a commit outside reset writes.
  always_ff @(posedge clk) begin
    if (!rst && commit) mem[commit_idx] <= commit_data;
  end

endmodule
